// File: rtl/spi_cmd_pkg.sv
// Shared constants, header field positions and FSM state encoding for the
// SPI command decoder.
package spi_cmd_pkg;

  localparam logic [7:0]  SYNC_BYTE      = 8'h5D;
  localparam logic [15:0] RESET_READBACK = 16'hA55A;

  // Header word layout: [15] rd, [14:ADDR_W+8] reserved, [ADDR_W+7:8] addr, [7:0] sync
  localparam int unsigned HDR_RD_BIT   = 15;
  localparam int unsigned HDR_ADDR_LSB = 8;
  localparam int unsigned HDR_SYNC_MSB = 7;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    DROP
  } state_t;

endpackage

// File: rtl/spi_cmd_regbank.sv
// NUM_REGS x 16 control register storage with write port, per-register
// write strobes, flattened output and a combinational read port.
// SPI_CMD_CHECKSUM_EN: writes land in a shadow bank and are copied to the
// live bank only when the frame checksum is accepted.
module spi_cmd_regbank #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [15:0]            wr_data,
`ifdef SPI_CMD_CHECKSUM_EN
  input  logic                   commit,
  input  logic                   discard,
`endif
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [15:0]            rd_data,
  output logic [NUM_REGS*16-1:0] regs_flat,
  output logic [NUM_REGS-1:0]    reg_wr_strobe
);

  logic [15:0] live [NUM_REGS];

`ifdef SPI_CMD_CHECKSUM_EN
  logic [15:0]         shadow [NUM_REGS];
  logic [NUM_REGS-1:0] touched;

  // Shadow bank capture and tracking of registers touched in this frame
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      touched <= '0;
    end else begin
      if (commit || discard) touched <= '0;
      if (wr_en) begin
        shadow[wr_idx]  <= wr_data;
        touched[wr_idx] <= 1'b1;
      end
    end
  end
`endif

  // Live bank update and one-cycle write strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) live[i] <= '0;
      reg_wr_strobe <= '0;
    end else begin
      reg_wr_strobe <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
      if (commit) begin
        for (int unsigned i = 0; i < NUM_REGS; i++)
          if (touched[i]) live[i] <= shadow[i];
        reg_wr_strobe <= touched;
      end
`else
      if (wr_en) begin
        live[wr_idx]          <= wr_data;
        reg_wr_strobe[wr_idx] <= 1'b1;
      end
`endif
    end
  end

  // Flatten the live bank and serve the read port
  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_flat[16*i +: 16] = live[i];
    rd_data = live[rd_idx];
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Frame parser between the SPI slave and the synth control register bank.
// Frames are a header word (rd, start address, sync byte) followed by data
// words written to consecutive registers, or a read request that loads the
// readback word for the next frame.
// SPI_CMD_CHECKSUM_EN: the last word of a write frame is an XOR checksum and
// the frame is committed atomically when chip-select drops.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_active,
  input  logic                   word_valid,
  input  logic [15:0]            word_in,
  output logic [15:0]            readback_out,
  output logic [NUM_REGS*16-1:0] regs_flat,
  output logic [NUM_REGS-1:0]    reg_wr_strobe,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned AW1   = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_END = PTR_W'(NUM_REGS);

  state_t            state, state_nxt;
  logic              fa_q, rd_q, frame_rise, hdr_ok, ptr_ok, wr_en;
  logic [PTR_W-1:0]  addr_ptr;
  logic [ADDR_W-1:0] hdr_addr;
  logic [14:0]       hdr_low;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [15:0]       wr_data, rd_data;

  assign frame_rise = frame_active & ~fa_q;
  assign hdr_addr   = word_in[HDR_ADDR_LSB +: ADDR_W];
  assign hdr_low    = word_in[14:0];
  assign hdr_ok     = (word_in[HDR_SYNC_MSB:0] == SYNC_BYTE)
                   && ((hdr_low >> (ADDR_W + HDR_ADDR_LSB)) == '0)
                   && ({1'b0, hdr_addr} < AW1'(NUM_REGS));
  assign ptr_ok     = (addr_ptr < PTR_END);
  assign busy       = (state != IDLE);
  assign rd_idx     = (state == HEADER) ? IDX_W'(hdr_addr) : addr_ptr[IDX_W-1:0];

`ifdef SPI_CMD_CHECKSUM_EN
  // Each data word is held one word back so the final one (the checksum)
  // never reaches the shadow bank; the check runs the cycle after the fall.
  logic [15:0]      xor_acc, pend_word;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_valid, pend_ok, end_chk, commit, discard;

  assign wr_en   = (state == DATA) && word_valid && !rd_q && pend_valid && pend_ok;
  assign wr_idx  = pend_idx;
  assign wr_data = pend_word;
  assign commit  = end_chk && pend_valid && (xor_acc == pend_word);
  assign discard = end_chk && !commit;
`else
  assign wr_en   = (state == DATA) && word_valid && !rd_q && ptr_ok;
  assign wr_idx  = addr_ptr[IDX_W-1:0];
  assign wr_data = word_in;
`endif

  spi_cmd_regbank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regbank (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
`ifdef SPI_CMD_CHECKSUM_EN
    .commit        (commit),
    .discard       (discard),
`endif
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .regs_flat     (regs_flat),
    .reg_wr_strobe (reg_wr_strobe)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; chip-select low overrides every transition
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_rise) state_nxt = HEADER;
      HEADER:  if (word_valid) state_nxt = hdr_ok ? DATA : DROP;
      DATA:    state_nxt = DATA;
      DROP:    state_nxt = DROP;
      default: state_nxt = IDLE;
    endcase
    if (!frame_active) state_nxt = IDLE;
  end

  // Header capture, address pointer, readback and error tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      fa_q         <= 1'b1;  // no edge seen until chip-select cycles after reset
      rd_q         <= 1'b0;
      addr_ptr     <= '0;
      readback_out <= RESET_READBACK;
      frame_err    <= 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
      xor_acc    <= '0;
      pend_word  <= '0;
      pend_idx   <= '0;
      pend_valid <= 1'b0;
      pend_ok    <= 1'b0;
      end_chk    <= 1'b0;
`endif
    end else begin
      fa_q <= frame_active;
      case (state)
        HEADER: if (word_valid) begin
          if (hdr_ok) begin
            frame_err <= 1'b0;
            rd_q      <= word_in[HDR_RD_BIT];
            addr_ptr  <= PTR_W'(hdr_addr);
            if (word_in[HDR_RD_BIT]) readback_out <= rd_data;
`ifdef SPI_CMD_CHECKSUM_EN
            xor_acc    <= word_in;
            pend_valid <= 1'b0;
`endif
          end else begin
            frame_err <= 1'b1;
          end
        end
        DATA: if (word_valid) begin
          if (addr_ptr != PTR_END) addr_ptr <= addr_ptr + 1'b1;
`ifdef SPI_CMD_CHECKSUM_EN
          if (rd_q) begin
            if (!ptr_ok) frame_err    <= 1'b1;
            else         readback_out <= rd_data;
          end else begin
            pend_word  <= word_in;
            pend_idx   <= addr_ptr[IDX_W-1:0];
            pend_ok    <= ptr_ok;
            pend_valid <= 1'b1;
            if (pend_valid) begin
              xor_acc <= xor_acc ^ pend_word;
              if (!pend_ok) frame_err <= 1'b1;
            end
          end
`else
          if (!ptr_ok)   frame_err    <= 1'b1;
          else if (rd_q) readback_out <= rd_data;
`endif
        end
        default: ;
      endcase
`ifdef SPI_CMD_CHECKSUM_EN
      end_chk <= (state == DATA) && !frame_active && !rd_q;
      if (end_chk) begin
        pend_valid <= 1'b0;
        if (pend_valid && !commit) frame_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: table of frames with expected
// frame_err, a reference register model, and a strobe scoreboard.
// Builds for both the plain and the SPI_CMD_CHECKSUM_EN variant.
module tb_spi_cmd_decoder;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned ADDR_W   = 7;

  logic                   clk = 1'b0;
  logic                   reset, frame_active, word_valid;
  logic [15:0]            word_in, readback_out;
  logic [NUM_REGS*16-1:0] regs_flat;
  logic [NUM_REGS-1:0]    reg_wr_strobe;
  logic                   frame_err, busy;

  spi_cmd_decoder #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_active  (frame_active),
    .word_valid    (word_valid),
    .word_in       (word_in),
    .readback_out  (readback_out),
    .regs_flat     (regs_flat),
    .reg_wr_strobe (reg_wr_strobe),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned idx;
    logic [15:0] val;
    int unsigned at;   // expected cycle of the strobe, 0 = any
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] hdr;
    int unsigned n;
    logic [15:0] d0, d1, d2;
    logic        exp_err;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  logic [15:0] model [NUM_REGS];
  logic [15:0] exp_rb;
  logic        watch_rb, rb_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_regs(input string name);
    int bad = -1;
    checks++;
    for (int i = 0; i < NUM_REGS; i++)
      if (bad < 0 && regs_flat[16*i +: 16] !== model[i]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: reg%0d got %h expected %h", name, bad, regs_flat[16*bad +: 16], model[bad]);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [15:0] hdr, input int unsigned n,
                              input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                              input logic exp_err);
    vec_t v;
    v.name = name; v.hdr = hdr; v.n = n; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic logic [15:0] dword(input vec_t v, input int unsigned k);
    return (k == 0) ? v.d0 : (k == 1) ? v.d1 : v.d2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    word_in    = w;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
  endtask

  // Scoreboard: every strobe bit must match the next expected write
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_wr_strobe[i]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got strobe on reg%0d expected none", i);
        end else begin
          e = sb.pop_front();
          check("strobe_idx", i, e.idx);
          check("strobe_data", regs_flat[16*i +: 16], e.val);
          if (e.at != 0) check("strobe_latency", cyc, e.at);
        end
      end
    end
  end

  always @(negedge clk)
    if (watch_rb && readback_out !== exp_rb) rb_bad = 1'b1;

  task automatic run_frame(input vec_t v);
    logic        good, rd;
    int unsigned a;
    logic [15:0] x;
    good = (v.hdr[7:0] == 8'h5D) && (v.hdr[14:8] < NUM_REGS);
    rd   = v.hdr[15];
    a    = v.hdr[14:8];
`ifdef SPI_CMD_CHECKSUM_EN
    if (good && !rd && v.n >= 1) begin
      x = v.hdr;
      for (int unsigned k = 0; k + 1 < v.n; k++) x ^= dword(v, k);
      if (x == dword(v, v.n - 1))
        for (int unsigned k = 0; k + 1 < v.n; k++)
          if (a + k < NUM_REGS) begin
            model[a+k] = dword(v, k);
            sb.push_back('{a + k, dword(v, k), 0});
          end
    end
`endif
    rb_bad       = 1'b0;
    watch_rb     = !(good && rd);
    frame_active = 1'b1;
    tick();
    tick();
    send_word(v.hdr);
    for (int unsigned k = 0; k < v.n; k++) begin
`ifndef SPI_CMD_CHECKSUM_EN
      if (good && !rd && a + k < NUM_REGS) begin
        model[a+k] = dword(v, k);
        sb.push_back('{a + k, dword(v, k), cyc + 1});
      end
`endif
      send_word(dword(v, k));
    end
    frame_active = 1'b0;
    repeat (4) tick();
    if (good && rd) exp_rb = model[a];
    check({v.name, "_frame_err"}, frame_err, v.exp_err);
    check({v.name, "_busy"}, busy, 1'b0);
    check({v.name, "_readback"}, readback_out, exp_rb);
    if (watch_rb) check({v.name, "_rb_stable"}, rb_bad, 1'b0);
    check_regs({v.name, "_regs"});
    watch_rb = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; frame_active = 1'b0; word_valid = 1'b0; word_in = '0;
    watch_rb = 1'b0; rb_bad = 1'b0; exp_rb = 16'hA55A;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    repeat (3) tick();
    check("reset_readback", readback_out, 16'hA55A);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_strobe", reg_wr_strobe, '0);
    check_regs("reset_regs");
    reset = 1'b0;
    tick();

`ifdef SPI_CMD_CHECKSUM_EN
    vecs.push_back(mk("ck_ok",      16'h015D, 2, 16'h0001, 16'h015C, 16'h0000, 1'b0));
    vecs.push_back(mk("ck_bad",     16'h015D, 2, 16'h0002, 16'h0000, 16'h0000, 1'b1));
    vecs.push_back(mk("ck_wr2",     16'h025D, 3, 16'h1234, 16'hBEEF, 16'hAE86, 1'b0));
    vecs.push_back(mk("ck_rd3",     16'h835D, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0));
    vecs.push_back(mk("ck_stable",  16'h045D, 2, 16'h0044, 16'h0419, 16'h0000, 1'b0));
    vecs.push_back(mk("ck_badsync", 16'h0200, 1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1));
    vecs.push_back(mk("ck_clear",   16'h055D, 2, 16'h0055, 16'h0508, 16'h0000, 1'b0));
    vecs.push_back(mk("ck_overrun", 16'h0F5D, 3, 16'h1111, 16'h2222, 16'h3C6E, 1'b1));
    vecs.push_back(mk("ck_rd15",    16'h8F5D, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0));
`else
    vecs.push_back(mk("wr2",        16'h025D, 2, 16'h1234, 16'hBEEF, 16'h0000, 1'b0));
    vecs.push_back(mk("rd3",        16'h835D, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0));
    vecs.push_back(mk("rb_stable",  16'h045D, 1, 16'h0044, 16'h0000, 16'h0000, 1'b0));
    vecs.push_back(mk("badsync",    16'h0200, 1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1));
    vecs.push_back(mk("err_clear",  16'h055D, 1, 16'h0055, 16'h0000, 16'h0000, 1'b0));
    vecs.push_back(mk("overrun",    16'h0F5D, 3, 16'h1111, 16'h2222, 16'h3333, 1'b1));
    vecs.push_back(mk("badaddr",    16'h105D, 1, 16'hAAAA, 16'h0000, 16'h0000, 1'b1));
    vecs.push_back(mk("rd15",       16'h8F5D, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0));
    vecs.push_back(mk("rd0",        16'h805D, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0));
`endif
    foreach (vecs[i]) run_frame(vecs[i]);

`ifndef SPI_CMD_CHECKSUM_EN
    // Abort after the first of two data words: the first write stays
    frame_active = 1'b1;
    tick(); tick();
    send_word(16'h065D);
    model[6] = 16'h6666;
    sb.push_back('{6, 16'h6666, cyc + 1});
    send_word(16'h6666);
    frame_active = 1'b0;
    repeat (3) tick();
    check("abort_frame_err", frame_err, 1'b0);
    check("abort_busy", busy, 1'b0);
    check_regs("abort_regs");

    // Data word in the same cycle chip-select falls is still written
    frame_active = 1'b1;
    tick(); tick();
    send_word(16'h085D);
    model[8] = 16'h8888;
    sb.push_back('{8, 16'h8888, cyc + 1});
    word_in = 16'h8888; word_valid = 1'b1; frame_active = 1'b0;
    tick();
    word_valid = 1'b0;
    check("fall_busy", busy, 1'b0);
    repeat (2) tick();
    check_regs("fall_regs");
`endif

    // Word while idle is ignored
    word_in = 16'h035D; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
    check("idle_word_busy", busy, 1'b0);
    check_regs("idle_word_regs");

    // Reset mid-frame, then the remainder of that frame is ignored
    frame_active = 1'b1;
    tick(); tick();
    send_word(16'h0900);
    send_word(16'h9999);
    check("pre_reset_err", frame_err, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    exp_rb = 16'hA55A;
    check("midreset_readback", readback_out, 16'hA55A);
    check("midreset_frame_err", frame_err, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check_regs("midreset_regs");
    send_word(16'h0A5D);
    send_word(16'h1111);
    check("midreset_ignore_busy", busy, 1'b0);
    frame_active = 1'b0;
    repeat (3) tick();
    check_regs("midreset_ignore_regs");
`ifdef SPI_CMD_CHECKSUM_EN
    run_frame(mk("post_reset", 16'h025D, 2, 16'h7777, 16'h752A, 16'h0000, 1'b0));
`else
    run_frame(mk("post_reset", 16'h025D, 1, 16'h7777, 16'h0000, 16'h0000, 1'b0));
`endif

    repeat (2) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Sits directly downstream of the SPI slave stage; consumes each received 16-bit word and the synced chip-select frame indication.
- Parses frames of the form header word followed by data words; drives a bank of 16-bit synth control registers (pitch, gain, waveform, etc.) for the I2S synth core.
- Produces the readback word that the SPI slave shifts out to the SAM on the next frame.

Parameters:
- NUM_REGS, 16, number of 16-bit control registers; power of two, 2..128.
- ADDR_W, 7, header address field width; log2(NUM_REGS) <= ADDR_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_active  in  1  high while chip-select is asserted, already synchronised to clk
- word_valid  in  1  one-cycle pulse; word_in holds a complete received word
- word_in  in  16  received SPI word
- readback_out  out  16  word presented to the SPI slave for transmit on the next frame
- regs_flat  out  NUM_REGS*16  live register contents; reg i occupies bits [16*i+15:16*i]
- reg_wr_strobe  out  NUM_REGS  one-cycle pulse per register updated
- frame_err  out  1  sticky; cleared by the next valid header
- busy  out  1  high while not in IDLE

Behaviour:
- Reset values:
  - all registers, regs_flat and reg_wr_strobe = 0
  - readback_out = 16'hA55A (link-check signature)
  - frame_err = 0, busy = 0, state = IDLE
- Header format:
  - [15] rd (1 = read, 0 = write)
  - [14:ADDR_W+8] reserved, must be 0; for ADDR_W=7 this field is [14:15], i.e. empty, and no check applies
  - [ADDR_W+7:8] start address
  - [7:0] must be 8'h5D as a sync byte
- State machine:
  - IDLE: rising edge of frame_active -> HEADER.
  - HEADER: word_valid with a good header -> DATA, addr_ptr <= start address. Bad sync byte, nonzero reserved bits, or start address >= NUM_REGS -> DROP, frame_err <= 1.
  - DATA: on each word_valid:
    - Write: if addr_ptr < NUM_REGS, reg[addr_ptr] <= word_in and reg_wr_strobe[addr_ptr] pulses the following cycle.
    - Read: data words are ignored; readback_out <= reg[addr_ptr].
    - addr_ptr increments after every word, saturating at NUM_REGS (no wrap). Words arriving at addr_ptr == NUM_REGS set frame_err and are discarded.
  - DROP: all words ignored.
  - Any state: frame_active low -> IDLE on the next cycle. This is an abort: no further writes, and a partial frame keeps the writes already done.
- Latency:
  - Register write is visible on regs_flat one cycle after word_valid.
  - A read header loads readback_out one cycle after word_valid, with reg[start address].
  - readback_out is held stable while frame_active is high. It changes only in HEADER/DATA of a read frame, or at reset.
- Simultaneous events:
  - word_valid in the same cycle that frame_active falls: the word is processed, then the state goes to IDLE.
  - word_valid while in IDLE is ignored.
- Reset mid-frame: immediate return to the reset values. The frame remainder is ignored until frame_active deasserts and reasserts.
- A header with rd=1 also writes nothing.

Optional Feature:
- Macro SPI_CMD_CHECKSUM_EN.
- With the macro:
  - Writes go to a shadow register bank, and a running XOR of the header and all data words is kept.
  - The last word of the frame is the checksum, so the final data word is treated as checksum and not written.
  - On frame_active falling: if the XOR of all words excluding the last equals the last word, the shadow bank is copied to the live bank in one cycle and reg_wr_strobe pulses for every register touched; otherwise nothing is committed and frame_err <= 1.
- Without the macro: writes go directly to the live bank as described above.

Decomposition:
- Shared package spi_cmd_pkg:
  - constants SYNC_BYTE = 8'h5D and RESET_READBACK = 16'hA55A
  - state encoding (IDLE, HEADER, DATA, DROP)
  - header field bit positions
- One natural sub-module, spi_cmd_regbank: the NUM_REGS x 16 storage with write port, strobe generation and flattened output. In the checksum variant it also holds the shadow bank and the commit logic.

Test Plan:
- Write frame: header 16'h025D, then 16'h1234 and 16'hBEEF -> reg2 = 16'h1234, reg3 = 16'hBEEF; strobes on bits 2 and 3 only; frame_err = 0.
- Read frame: header 16'h835D, then next frame -> readback_out = current reg3 value, stable throughout the next frame.
- Bad sync: header 16'h0200 followed by data 16'hFFFF -> no register changes; frame_err = 1. A following good frame clears frame_err.
- Overrun: NUM_REGS=16, header 16'h0F5D with 3 data words -> only reg15 written; frame_err = 1; no wrap to reg0.
- Abort/reset: frame_active drops after 1 of 2 data words -> first write kept. reset mid-frame -> all regs = 0, readback_out = 16'hA55A.
- With SPI_CMD_CHECKSUM_EN: header 16'h015D, data 16'h0001, checksum 16'h015C -> reg1 = 1 committed at frame end. Same frame with checksum 16'h0000 -> nothing committed; frame_err = 1.
